// File: rtl/pisa_ctrl_pkg.sv
// rtl/pisa_ctrl_pkg.sv - control-word encodings, sequencer states and jump-condition helper
package pisa_ctrl_pkg;

  typedef enum logic [2:0] {
    WR_NONE  = 3'd0,
    WR_ALU   = 3'd1,
    WR_RSRC2 = 3'd2,
    WR_MEM   = 3'd3,
    WR_IMM   = 3'd4
  } wr_src_e;

  typedef enum logic [1:0] {
    WM_NONE  = 2'd0,
    WM_RSRC1 = 2'd1,
    WM_IMM   = 2'd2
  } wm_src_e;

  typedef enum logic [1:0] {
    JMP_NONE  = 2'd0,
    JMP_RDEST = 2'd1,
    JMP_IMM   = 2'd2,
    JMP_ADDR  = 2'd3
  } jmp_src_e;

  typedef enum logic [2:0] {
    JC_ALWAYS = 3'b000,
    JC_Z      = 3'b010,
    JC_NZ     = 3'b011,
    JC_N      = 3'b100,
    JC_NN     = 3'b101
  } jcond_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALTED
  } seq_state_t;

  // Unlisted condition codes are deliberately never taken.
  function automatic logic jump_taken(input logic [2:0] jcond, input logic z, input logic n);
    case (jcond)
      JC_ALWAYS: jump_taken = 1'b1;
      JC_Z:      jump_taken = z;
      JC_NZ:     jump_taken = ~z;
      JC_N:      jump_taken = n;
      JC_NN:     jump_taken = ~n;
      default:   jump_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - memory-stall counter producing a one-cycle timeout pulse
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam logic [TO_W-1:0] LAST_STALL = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic            stall;

  assign stall     = active_i & ~ready_i;
  // Fires on the stalled cycle that would be number TIMEOUT_CYCLES; a ready that cycle suppresses it.
  assign timeout_o = stall && (cnt_q == LAST_STALL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!stall || timeout_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle PISA control FSM owning the shared memory port
module core_sequencer
  import pisa_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cs_halt,
  input  logic [2:0]  cs_wr_src,
  input  logic [1:0]  cs_wm_src,
  input  logic [1:0]  cs_jmp_src,
  input  logic [2:0]  cs_jcond,
  input  logic        flag_zero,
  input  logic        flag_negative,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [1:0]  pc_load_sel,
  output logic        alu_flags_load,
  output logic        rf_we,
  output logic [2:0]  rf_wr_sel,
  output logic        retire,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_cnt
);

  seq_state_t  state_q;
  logic        fault_q;
  logic [31:0] retired_cnt_q;
  logic        timeout;
  logic        is_jump, is_store, is_mem, is_write, taken;

  assign is_jump  = (cs_jmp_src != JMP_NONE);
  assign is_store = (cs_wm_src != WM_NONE);
  assign is_mem   = is_store || (cs_wr_src == WR_MEM);
  assign is_write = (cs_wr_src != WR_NONE);
  assign taken    = jump_taken(cs_jcond, flag_zero, flag_negative);

  seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .active_i  ((state_q == S_FETCH) || (state_q == S_MEM)),
    .ready_i   (mem_ready),
    .timeout_o (timeout)
  );

  always_comb begin
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr_sel   = 1'b0;
    ir_load        = 1'b0;
    pc_inc         = 1'b0;
    pc_load        = 1'b0;
    alu_flags_load = 1'b0;
    rf_we          = 1'b0;
    retire         = 1'b0;
    pc_load_sel    = cs_jmp_src;
    rf_wr_sel      = cs_wr_src;
    halted         = (state_q == S_HALTED);
    fault          = fault_q;
    retired_cnt    = retired_cnt_q;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
      end
      S_EXECUTE: begin
        if (cs_halt) begin
          retire = 1'b1;
        end else if (is_jump) begin
          pc_load = taken;
          retire  = 1'b1;
        end else if (is_mem) begin
          retire = 1'b0;
        end else if (is_write) begin
          alu_flags_load = (cs_wr_src == WR_ALU);
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        retire       = mem_ready && is_store;
      end
      S_WRITEBACK: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fault_q       <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      if (retire) retired_cnt_q <= retired_cnt_q + 32'd1;
      if (timeout) begin
        fault_q <= 1'b1;
        state_q <= S_HALTED;
      end else begin
        case (state_q)
          S_IDLE:      if (start) state_q <= S_FETCH;
          S_FETCH:     if (mem_ready) state_q <= S_DECODE;
          S_DECODE:    state_q <= S_EXECUTE;
          S_EXECUTE: begin
            if (cs_halt)       state_q <= S_HALTED;
            else if (is_jump)  state_q <= S_FETCH;
            else if (is_mem)   state_q <= S_MEM;
            else if (is_write) state_q <= S_WRITEBACK;
            else               state_q <= S_FETCH;
          end
          S_MEM:       if (mem_ready) state_q <= is_store ? S_FETCH : S_WRITEBACK;
          S_WRITEBACK: state_q <= S_FETCH;
          S_HALTED:    if (start && !fault_q) state_q <= S_FETCH;
          default:     state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
